// File: rtl/matrix_reader.sv
// rtl/matrix_reader.sv - big-endian byte stream to indexed 32-bit matrix elements
// Optional feature macro: MATRIX_READER_CHECKSUM_EN (adds checksum[31:0], XOR of accepted elements).
// Elements arrive as 4 bytes MSB first, row-major, n x n; each one is presented
// with its (i, j) index on a valid/ready handshake toward the matrix buffer.
module matrix_reader #(
   parameter int n     = 8,
   parameter int n_len = $clog2(n)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   output logic             byte_ready,
   output logic [31:0]      value,
   output logic             value_valid,
   input  logic             value_ready,
   output logic [n_len:0]   i,
   output logic [n_len:0]   j,
   output logic             busy,
   output logic             done
`ifdef MATRIX_READER_CHECKSUM_EN
   ,
   output logic [31:0]      checksum
`endif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ASSEMBLE = 2'd1,
      EMIT     = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [n_len:0] last_idx = (n_len + 1)'(n - 1);
   localparam logic [n_len:0] zero_idx = '0;
   localparam logic [n_len:0] one_idx  = (n_len + 1)'(1);

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [31:0]      value_q, value_d;
   logic             value_valid_q, value_valid_d;
   logic             byte_ready_q, byte_ready_d;
   logic [n_len:0]   i_q, i_d;
   logic [n_len:0]   j_q, j_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef MATRIX_READER_CHECKSUM_EN
   logic [31:0]      checksum_q, checksum_d;
`endif

   logic byte_take;
   logic elem_take;
   logic start_take;

   assign byte_take  = byte_valid & byte_ready_q;
   assign elem_take  = value_valid_q & value_ready;
   // start only matters when no load is running; it is ignored in ASSEMBLE/EMIT
   assign start_take = start & ((state_q == IDLE) | (state_q == DONE));

   // Next-state and next-output computation for the load sequencer
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      value_d       = value_q;
      value_valid_d = value_valid_q;
      byte_ready_d  = byte_ready_q;
      i_d           = i_q;
      j_d           = j_q;
      busy_d        = busy_q;
      done_d        = done_q;

      case (state_q)
         IDLE, DONE: begin
            if (start_take) begin
               state_d       = ASSEMBLE;
               cnt_d         = 2'd0;
               value_valid_d = 1'b0;
               byte_ready_d  = 1'b1;
               i_d           = zero_idx;
               j_d           = zero_idx;
               busy_d        = 1'b1;
               done_d        = 1'b0;
            end
         end

         ASSEMBLE: begin
            if (byte_take) begin
               // byte k of the element lands in value[31-8k -: 8]
               case (cnt_q)
                  2'd0:    value_d[31:24] = byte_in;
                  2'd1:    value_d[23:16] = byte_in;
                  2'd2:    value_d[15:8]  = byte_in;
                  default: value_d[7:0]   = byte_in;
               endcase
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_d       = EMIT;
                  byte_ready_d  = 1'b0;
                  value_valid_d = 1'b1;
               end
            end
         end

         EMIT: begin
            if (elem_take) begin
               value_valid_d = 1'b0;
               cnt_d         = 2'd0;
               if (j_q != last_idx) begin
                  j_d          = j_q + one_idx;
                  state_d      = ASSEMBLE;
                  byte_ready_d = 1'b1;
               end else if (i_q != last_idx) begin
                  j_d          = zero_idx;
                  i_d          = i_q + one_idx;
                  state_d      = ASSEMBLE;
                  byte_ready_d = 1'b1;
               end else begin
                  // last element delivered; i and j stay at n-1
                  state_d      = DONE;
                  byte_ready_d = 1'b0;
                  busy_d       = 1'b0;
                  done_d       = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

`ifdef MATRIX_READER_CHECKSUM_EN
   // Running XOR over every element handed downstream, restarted with each load
   always_comb begin
      checksum_d = checksum_q;
      if (start_take) begin
         checksum_d = 32'd0;
      end else if (elem_take) begin
         checksum_d = checksum_q ^ value_q;
      end
   end
`endif

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 2'd0;
         value_q       <= 32'd0;
         value_valid_q <= 1'b0;
         byte_ready_q  <= 1'b0;
         i_q           <= zero_idx;
         j_q           <= zero_idx;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
`ifdef MATRIX_READER_CHECKSUM_EN
         checksum_q    <= 32'd0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         value_q       <= value_d;
         value_valid_q <= value_valid_d;
         byte_ready_q  <= byte_ready_d;
         i_q           <= i_d;
         j_q           <= j_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
`ifdef MATRIX_READER_CHECKSUM_EN
         checksum_q    <= checksum_d;
`endif
      end
   end

   assign byte_ready  = byte_ready_q;
   assign value       = value_q;
   assign value_valid = value_valid_q;
   assign i           = i_q;
   assign j           = j_q;
   assign busy        = busy_q;
   assign done        = done_q;
`ifdef MATRIX_READER_CHECKSUM_EN
   assign checksum    = checksum_q;
`endif

endmodule

// File: tb/tb_matrix_reader.sv
// tb/tb_matrix_reader.sv - directed self-checking bench for matrix_reader (n=2)
module tb_matrix_reader;

   localparam int n = 2;
   localparam int n_len = $clog2(n);

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [7:0]     byte_in;
   logic           byte_valid;
   logic           byte_ready;
   logic [31:0]    value;
   logic           value_valid;
   logic           value_ready;
   logic [n_len:0] i;
   logic [n_len:0] j;
   logic           busy;
   logic           done;
`ifdef MATRIX_READER_CHECKSUM_EN
   logic [31:0]    checksum;
`endif

   int errors = 0;
   int checks = 0;

   matrix_reader #(.n(n)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .byte_ready  (byte_ready),
      .value       (value),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .i           (i),
      .j           (j),
      .busy        (busy),
      .done        (done)
`ifdef MATRIX_READER_CHECKSUM_EN
      ,
      .checksum    (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      while (!byte_ready && t < 50) begin
         tick();
         t++;
      end
      if (t >= 50) check("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
      byte_in    = b;
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      byte_in    = 8'h00;
   endtask

   // sends one element; gap idles byte_valid that many cycles before byte 2
   task automatic send_elem(input string tag, input logic [31:0] w, input int gap,
                            input logic [31:0] ei, input logic [31:0] ej);
      int t;
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      for (int g = 0; g < gap; g++) tick();
      send_byte(w[15:8]);
      send_byte(w[7:0]);
      t = 0;
      while (!value_valid && t < 50) begin
         tick();
         t++;
      end
      check({tag, "_valid"}, {31'd0, value_valid}, 32'd1);
      check({tag, "_value"}, value, w);
      check({tag, "_i"}, 32'(i), ei);
      check({tag, "_j"}, 32'(j), ej);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
      check({tag, "_value"}, value, 32'd0);
      check({tag, "_value_valid"}, {31'd0, value_valid}, 32'd0);
      check({tag, "_i"}, 32'(i), 32'd0);
      check({tag, "_j"}, 32'(j), 32'd0);
      check({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check({tag, "_done"}, {31'd0, done}, 32'd0);
`ifdef MATRIX_READER_CHECKSUM_EN
      check({tag, "_checksum"}, checksum, 32'd0);
`endif
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      byte_in     = 8'h00;
      byte_valid  = 1'b0;
      value_ready = 1'b0;
      tick();
      tick();
      check_reset_state("rst");
      rst_n = 1'b1;
      tick();
      check_reset_state("idle");

      // full 2x2 load with downstream always ready
      value_ready = 1'b1;
      pulse_start();
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_byte_ready", {31'd0, byte_ready}, 32'd1);
      send_elem("e00", 32'h0000_0001, 0, 0, 0);
      send_elem("e01", 32'h0000_0002, 0, 0, 1);
      send_elem("e10", 32'h0000_0003, 0, 1, 0);
      send_elem("e11", 32'h0000_0004, 0, 1, 1);
      tick();
      check("fin_done", {31'd0, done}, 32'd1);
      check("fin_busy", {31'd0, busy}, 32'd0);
      check("fin_value_valid", {31'd0, value_valid}, 32'd0);
      check("fin_byte_ready", {31'd0, byte_ready}, 32'd0);
      check("fin_i", 32'(i), 32'd1);
      check("fin_j", 32'(j), 32'd1);
`ifdef MATRIX_READER_CHECKSUM_EN
      check("fin_checksum", checksum, 32'h0000_0004);
`endif
      tick();
      check("done_level", {31'd0, done}, 32'd1);

      // restart from DONE, byte order and backpressure on element (0,0)
      value_ready = 1'b0;
      pulse_start();
      check("restart_done", {31'd0, done}, 32'd0);
      check("restart_busy", {31'd0, busy}, 32'd1);
      check("restart_i", 32'(i), 32'd0);
      check("restart_j", 32'(j), 32'd0);
`ifdef MATRIX_READER_CHECKSUM_EN
      check("restart_checksum", checksum, 32'd0);
`endif
      send_elem("order", 32'hDEAD_BEEF, 0, 0, 0);
      for (int c = 0; c < 6; c++) begin
         tick();
         check("bp_value", value, 32'hDEAD_BEEF);
         check("bp_valid", {31'd0, value_valid}, 32'd1);
         check("bp_byte_ready", {31'd0, byte_ready}, 32'd0);
         check("bp_ij", {30'd0, i, j}, 32'd0);
      end
      value_ready = 1'b1;
      tick();
      check("bp_rel_j", 32'(j), 32'd1);
      check("bp_rel_i", 32'(i), 32'd0);
      check("bp_rel_valid", {31'd0, value_valid}, 32'd0);
      check("bp_rel_byte_ready", {31'd0, byte_ready}, 32'd1);

      // start while busy is ignored
      pulse_start();
      check("busy_start_j", 32'(j), 32'd1);
      check("busy_start_busy", {31'd0, busy}, 32'd1);

      // gapped input on element (0,1)
      send_elem("gap", 32'h1234_5678, 3, 0, 1);
      tick();
      check("gap_next_i", 32'(i), 32'd1);
      check("gap_next_j", 32'(j), 32'd0);

      // reset after two bytes of the next element
      send_byte(8'hAA);
      send_byte(8'hBB);
      rst_n = 1'b0;
      tick();
      check_reset_state("midrst");
      rst_n = 1'b1;
      tick();
      pulse_start();
      send_elem("after_rst", 32'h1122_3344, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
